div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 178 +++++++++++++++++
 tb/tb_div_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq -- multi-cycle restoring divider for the EX stage (DIV / DIVU).
//
// One quotient bit is produced per clock. A nonzero-divisor divide takes
// WIDTH+1 edges from the accepting edge to ready_o. A zero divisor goes
// through BYZERO and returns all zeros one edge after acceptance.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled only on the accepting edge in IDLE
//   opdata2_i     divisor, sampled only on the accepting edge in IDLE
//   start_i       divide request, held high until the result is taken
//   annul_i       flush: abandons a divide in ON or BYZERO
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   busy_o        high in ON or BYZERO, decoded from state (stall request)
// ----------------------------------------------------------------------------
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  // Layout: [2W:W+1] partial remainder, [W:1] remaining dividend bits,
  // quotient bits shifted in from [0].
  logic [2*WIDTH:0]   work, work_next;
  logic [WIDTH-1:0]   divisor, divisor_next;
  logic               neg_a, neg_a_next;
  logic               neg_b, neg_b_next;
  logic               signed_q, signed_q_next;
  logic [2*WIDTH-1:0] result_next;
  logic               ready_next;

  logic               in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;

  assign busy_o = (state == ON) || (state == BYZERO);

  // Operand magnitudes for the accepting edge.
  assign in_neg_a = signed_div_i & opdata1_i[WIDTH-1];
  assign in_neg_b = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a    = in_neg_a ? (~opdata1_i + ONE) : opdata1_i;
  assign abs_b    = in_neg_b ? (~opdata2_i + ONE) : opdata2_i;

  // Trial subtract: shifted partial remainder (with next dividend bit
  // already in place) minus divisor; bit WIDTH set means it went negative.
  assign diff = {1'b0, work[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

  assign quot     = work[WIDTH-1:0];
  assign rem      = work[2*WIDTH:WIDTH+1];
  assign quot_fix = (signed_q && (neg_a ^ neg_b)) ? (~quot + ONE) : quot;
  assign rem_fix  = (signed_q && neg_a) ? (~rem + ONE) : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      signed_q <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      work     <= work_next;
      divisor  <= divisor_next;
      neg_a    <= neg_a_next;
      neg_b    <= neg_b_next;
      signed_q <= signed_q_next;
      result_o <= result_next;
      ready_o  <= ready_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    work_next     = work;
    divisor_next  = divisor;
    neg_a_next    = neg_a;
    neg_b_next    = neg_b;
    signed_q_next = signed_q;
    result_next   = result_o;
    ready_next    = ready_o;

    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = BYZERO;
          end else begin
            state_next    = ON;
            cnt_next      = '0;
            work_next     = {{WIDTH{1'b0}}, abs_a, 1'b0};
            divisor_next  = abs_b;
            neg_a_next    = in_neg_a;
            neg_b_next    = in_neg_b;
            signed_q_next = signed_div_i;
          end
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_next  = IDLE;
          result_next = '0;
          ready_next  = 1'b0;
        end else begin
          state_next  = END;
          result_next = '0;
          ready_next  = 1'b1;
        end
      end

      ON: begin
        if (annul_i) begin
          state_next  = IDLE;
          result_next = '0;
          ready_next  = 1'b0;
        end else if (cnt != CNT_LAST) begin
          if (diff[WIDTH]) begin
            work_next = {work[2*WIDTH-1:0], 1'b0};
          end else begin
            work_next = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          end
          cnt_next = cnt + CNT_ONE;
        end else begin
          state_next  = END;
          result_next = {rem_fix, quot_fix};
          ready_next  = 1'b1;
        end
      end

      END: begin
        if (!start_i) begin
          state_next  = IDLE;
          result_next = '0;
          ready_next  = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  // Reference: plain arithmetic on 64-bit integers; truncating division,
  // remainder takes the dividend's sign, results wrap to 32 bits.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues a divide, scrambles operands after acceptance, waits (bounded)
  // for ready_o. lat = edges after the accepting edge; busy_cnt = samples
  // with busy_o high before ready.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output logic [63:0] res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    lat = 0;
    busy_cnt = 0;
    while (!ready_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      tick();
      lat++;
    end
    res = result_o;
  endtask

  task automatic release_start;
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready_o); else n_pass++;
    n_checks++; if (result_o !== 64'd0) $display("FAIL reset_result got=%h want=0", result_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o); else n_pass++;
  endtask

  task automatic test_unsigned_basic;
    int lat, bc; logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, lat, bc, res);
    n_checks++; if (lat !== 33) $display("FAIL u100_7_latency got=%0d want=33", lat); else n_pass++;
    n_checks++; if (bc !== 33) $display("FAIL u100_7_busy_cycles got=%0d want=33", bc); else n_pass++;
    n_checks++; if (res !== 64'h00000002_0000000E) $display("FAIL u100_7_result got=%h want=%h", res, 64'h00000002_0000000E); else n_pass++;
    // END holds with start high and ignores annul.
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL end_hold_ready got=%b want=1", ready_o); else n_pass++;
    n_checks++; if (result_o !== 64'h00000002_0000000E) $display("FAIL end_hold_result got=%h want=%h", result_o, 64'h00000002_0000000E); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL end_busy got=%b want=0", busy_o); else n_pass++;
    release_start();
    n_checks++; if (ready_o !== 1'b0) $display("FAIL end_release_ready got=%b want=0", ready_o); else n_pass++;
    n_checks++; if (result_o !== 64'd0) $display("FAIL end_release_result got=%h want=0", result_o); else n_pass++;
  endtask

  task automatic test_signed_basic;
    int lat, bc; logic [63:0] res;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, bc, res);
    n_checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL s_m7_2_result got=%h want=%h", res, 64'hFFFFFFFF_FFFFFFFD); else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL s_m7_2_latency got=%0d want=33", lat); else n_pass++;
    release_start();
  endtask

  task automatic test_div_zero;
    int lat, bc; logic [63:0] res;
    run_div(1'b0, 32'd1234, 32'd0, lat, bc, res);
    n_checks++; if (lat !== 1) $display("FAIL byzero_latency got=%0d want=1", lat); else n_pass++;
    n_checks++; if (bc !== 1) $display("FAIL byzero_busy_cycles got=%0d want=1", bc); else n_pass++;
    n_checks++; if (res !== 64'd0) $display("FAIL byzero_result got=%h want=0", res); else n_pass++;
    release_start();
    n_checks++; if (ready_o !== 1'b0) $display("FAIL byzero_release_ready got=%b want=0", ready_o); else n_pass++;
    // Flush while in BYZERO.
    signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    n_checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL byzero_annul got ready=%b busy=%b want 0/0", ready_o, busy_o); else n_pass++;
  endtask

  task automatic test_annul;
    int lat, bc, seen; logic [63:0] res;
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1; start_i = 1'b1;
    tick();                 // accepted, cnt = 0
    repeat (10) tick();     // cnt = 10
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL annul_busy got=%b want=0", busy_o); else n_pass++;
    n_checks++; if (result_o !== 64'd0) $display("FAIL annul_result got=%h want=0", result_o); else n_pass++;
    seen = 0;
    repeat (40) begin
      if (ready_o) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL annul_ready_seen got=%0d want=0", seen); else n_pass++;
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, bc, res);
    n_checks++; if (res !== 64'h00000000_FFFFFFFF) $display("FAIL annul_rerun_result got=%h want=%h", res, 64'h00000000_FFFFFFFF); else n_pass++;
    release_start();
  endtask

  task automatic test_overflow;
    int lat, bc; logic [63:0] res;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc, res);
    n_checks++; if (res !== 64'h00000000_80000000) $display("FAIL s_min_m1_result got=%h want=%h", res, 64'h00000000_80000000); else n_pass++;
    release_start();
  endtask

  task automatic test_rst_mid;
    int lat, bc; logic [63:0] res;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (20) tick();     // cnt = 20
    rst = 1'b1;
    tick();
    n_checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0)
      $display("FAIL rst_mid_outputs got ready=%b busy=%b result=%h want all 0", ready_o, busy_o, result_o);
    else n_pass++;
    rst = 1'b0; start_i = 1'b0;
    tick();
    run_div(1'b0, 32'd9, 32'd3, lat, bc, res);
    n_checks++; if (res !== 64'h00000000_00000003) $display("FAIL rst_rerun_result got=%h want=%h", res, 64'h00000000_00000003); else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL rst_rerun_latency got=%0d want=33", lat); else n_pass++;
    release_start();
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [63:0] res, exp;
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, lat, bc, res);
    exp = ref_div(1'b1, 32'hFFFFFF9C, 32'd7);
    n_checks++; if (res !== exp) $display("FAIL b2b_first got=%h want=%h", res, exp); else n_pass++;
    release_start();
    run_div(1'b0, 32'hDEADBEEF, 32'h00012345, lat, bc, res);
    exp = ref_div(1'b0, 32'hDEADBEEF, 32'h00012345);
    n_checks++; if (res !== exp) $display("FAIL b2b_second got=%h want=%h", res, exp); else n_pass++;
    n_checks++; if (lat !== 33) $display("FAIL b2b_second_latency got=%0d want=33", lat); else n_pass++;
    release_start();
  endtask

  task automatic test_random;
    int lat, bc, want_lat; logic [63:0] res, exp;
    logic sgn; logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (i == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; sgn = 1'b1; end
      run_div(sgn, a, b, lat, bc, res);
      exp = ref_div(sgn, a, b);
      want_lat = (b == 32'd0) ? 1 : 33;
      n_checks++; if (res !== exp) $display("FAIL rand_result[%0d] sgn=%b a=%h b=%h got=%h want=%h", i, sgn, a, b, res, exp); else n_pass++;
      n_checks++; if (lat !== want_lat) $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, want_lat); else n_pass++;
      release_start();
      n_checks++; if (ready_o !== 1'b0) $display("FAIL rand_release[%0d] got=%b want=0", i, ready_o); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_basic();
    test_div_zero();
    test_annul();
    test_overflow();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
